// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - types and helpers for the button event classifier
// Purpose: FSM state encoding and a small integer helper.
// Ports: none (package).
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared timing configuration for the button input path
// Purpose: system clock frequency and the debounce and click timing defaults.
// Ports: none (package).
package config_pkg;

  localparam int ClkFreq    = 100_000_000;  // Hz
  localparam int StableTime = 10;           // ms, debouncer settle time
  localparam int LongTime   = 1000;         // ms, long-press threshold
  localparam int GapTime    = 250;          // ms, max release gap for a double click

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered-level edge detector
// Purpose: compares a level with its one-cycle registered copy.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   level in   level to watch
//   rise  out  level is 1 now and was 0 one cycle ago
//   fall  out  level is 0 now and was 1 one cycle ago
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev;
  logic armed;

  // armed stays low for the first cycle after reset so that a level already
  // high when reset releases is absorbed into prev instead of reading as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= 1'b1;
    end
  end

  assign rise = armed &  level & ~prev;
  assign fall = armed & ~level &  prev;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - classifies a debounced button into short, long and double events
// Purpose: FSM with a saturating cycle counter timing press length and release gap.
// Ports:
//   clk_i       in   system clock, rising edge
//   rst_i       in   asynchronous active-high reset
//   en_i        in   controller enable; low forces IDLE
//   db_level_i  in   debounced switch level (1 = pressed)
//   short_o     out  one-cycle pulse, single short click
//   long_o      out  one-cycle pulse, long press
//   double_o    out  one-cycle pulse, double click
//   busy_o      out  high whenever state is not IDLE
//   state_o     out  current state encoding, debug
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int ClkFreq  = config_pkg::ClkFreq,
  parameter int LongTime = config_pkg::LongTime,
  parameter int GapTime  = config_pkg::GapTime
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       db_level_i,
  output logic       short_o,
  output logic       long_o,
  output logic       double_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  localparam int LongCycles = ClkFreq / 1000 * LongTime;
  localparam int GapCycles  = ClkFreq / 1000 * GapTime;
  localparam int CntW       = $clog2(max_int(LongCycles, GapCycles) + 1);

  localparam logic [CntW-1:0] LongLast = CntW'(LongCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);

  if (LongCycles < 2 || GapCycles < 2) begin : g_bad_timing
    $error("btn_event_ctrl: LongCycles and GapCycles must both be at least 2");
  end

  logic            rise;
  logic            fall;
  btn_state_e      state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;

  edge_det u_edge (
    .clk   (clk_i),
    .rst   (rst_i),
    .level (db_level_i),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating increment: the counter parks at all-ones rather than wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Edge tests come before timeout tests in every state, so an edge landing
  // on the timeout cycle takes priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
    end else begin
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
      if (!en_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= PRESS1;
              cnt   <= '0;
            end
          end
          PRESS1: begin
            if (fall) begin
              state <= GAP;
              cnt   <= '0;
            end else if (cnt == LongLast) begin
              state  <= HOLD;
              long_o <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HOLD: begin
            if (fall) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          GAP: begin
            if (rise) begin
              state <= PRESS2;
              cnt   <= '0;
            end else if (cnt == GapLast) begin
              state   <= IDLE;
              cnt     <= '0;
              short_o <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRESS2: begin
            if (fall) begin
              state    <= IDLE;
              cnt      <= '0;
              double_o <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign busy_o  = (state != IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - directed self-checking bench for btn_event_ctrl
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       level;
  logic       short_p;
  logic       long_p;
  logic       double_p;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .ClkFreq  (1000),
    .LongTime (5),
    .GapTime  (3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .db_level_i (level),
    .short_o    (short_p),
    .long_o     (long_p),
    .double_o   (double_p),
    .busy_o     (busy),
    .state_o    (state)
  );

  task automatic chk(input string tag, input int sc, input int c,
                     input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s sc%0d cyc %0d got %b exp %b", tag, sc, c, got, exp);
    end
  endtask

  // Cycle c is the period after the c-th rising edge following reset release.
  // Inputs for cycle c are driven at edge+1; registered outputs seen then
  // belong to cycle c.
  task automatic run(input int sc);
    logic es, el, ed, eb;
    int   ps;
    rst   = 1'b1;
    en    = (sc != 6);
    level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulses", sc, 0, {double_p, long_p, short_p}, 3'b000);
    chk("reset_busy",   sc, 0, {2'b00, busy}, 3'b000);
    chk("reset_state",  sc, 0, state, 3'd0);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      es = 1'b0; el = 1'b0; ed = 1'b0; eb = 1'b0; ps = -1;
      case (sc)
        1: begin  // short click
          level = (c >= 10 && c < 12);
          es = (c == 16);
          eb = (c >= 11 && c <= 15);
          if (c == 13) ps = 3;
        end
        2: begin  // long press, released at 30
          level = (c >= 10 && c < 30);
          el = (c == 16);
          eb = (c >= 11 && c <= 30);
          if (c == 12) ps = 1;
          if (c == 16) ps = 2;
          if (c == 31) ps = 0;
        end
        3: begin  // double click
          level = (c >= 10 && c < 12) || (c == 14);
          ed = (c == 16);
          eb = (c >= 11 && c <= 15);
          if (c == 15) ps = 4;
        end
        4: begin  // release coincides with long timeout
          level = (c >= 10 && c < 15);
          es = (c == 19);
          eb = (c >= 11 && c <= 18);
          if (c == 16) ps = 3;
        end
        5: begin  // reset mid-press
          level = (c >= 10 && c < 20);
          eb = (c == 11);
          if (c >= 12) ps = 0;
        end
        6: begin  // disabled toggling, enable while held, then a real click
          level = (c >= 3 && c < 5) || (c >= 7 && c < 10) || (c >= 15 && c < 25) || (c == 30);
          en = (c >= 20);
          es = (c == 35);
          eb = (c >= 31 && c <= 34);
          if (c == 26) ps = 0;
        end
        default: ;
      endcase
      if (sc == 5 && c == 12) begin
        rst = 1'b1;
        #1;
        chk("async_reset_state", sc, c, state, 3'd0);
        rst = 1'b0;
      end
      chk("pulses", sc, c, {double_p, long_p, short_p}, {ed, el, es});
      chk("busy",   sc, c, {2'b00, busy}, {2'b00, eb});
      if (ps >= 0) chk("state", sc, c, state, 3'(ps));
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    level = 1'b0;
    run(1);
    run(2);
    run(3);
    run(4);
    run(5);
    run(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter ClkFreq, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter LongTime, default 1000, long-press threshold in ms.
REQ-003 Parameter GapTime, default 250, maximum release gap for a double click, in ms.
REQ-004 clk_i  input  1  single system clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 en_i  input  1  controller enable; low forces IDLE.
REQ-007 db_level_i  input  1  debounced switch level from the debouncer (1 = pressed).
REQ-008 short_o  output  1  one-cycle pulse: single short click classified.
REQ-009 long_o  output  1  one-cycle pulse: long press classified.
REQ-010 double_o  output  1  one-cycle pulse: double click classified.
REQ-011 busy_o  output  1  high whenever state is not IDLE.
REQ-012 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-013 LongCycles = ClkFreq/1000*LongTime and GapCycles = ClkFreq/1000*GapTime; both SHALL be >= 2 (elaboration error otherwise).
REQ-014 Counter width = $clog2(max(LongCycles,GapCycles)+1); counter saturates, never wraps.
REQ-015 Edges: db_level_i is compared with its 1-cycle registered copy; rise = 1 now and 0 before, fall = 0 now and 1 before.
REQ-016 States: IDLE, PRESS1, HOLD, GAP, PRESS2.
REQ-017 IDLE: rise -> PRESS1, counter cleared.
REQ-018 PRESS1: counter increments each cycle; fall -> GAP with counter cleared; counter == LongCycles-1 with no fall -> HOLD and long_o pulse.
REQ-019 HOLD: fall -> IDLE; no further pulses.
REQ-020 GAP: counter increments each cycle; rise -> PRESS2; counter == GapCycles-1 with no rise -> IDLE and short_o pulse.
REQ-021 PRESS2: fall -> IDLE and double_o pulse; long hold in PRESS2 produces no long_o.
REQ-022 An edge in the same cycle as a timeout SHALL win (PRESS1 fall beats long, GAP rise beats short).
REQ-023 Output pulses SHALL be registered, exactly one cycle wide, and mutually exclusive.
REQ-024 Latency: long_o is high LongCycles+1 cycles after the rise cycle; short_o is high GapCycles+1 cycles after the fall cycle; double_o is high 1 cycle after the second fall cycle.
REQ-025 en_i low: next state IDLE, counter cleared, no pulses; the edge register keeps tracking db_level_i.
REQ-026 en_i rising while db_level_i is already high SHALL NOT generate a rise.

Reset
REQ-027 rst_i high SHALL asynchronously force IDLE, counter 0, edge register 0, and all outputs 0 (state_o = IDLE encoding).
REQ-028 Reset mid-sequence SHALL discard the pending classification with no pulse after release; a level still high after reset SHALL NOT count as a rise.

Structure
REQ-029 btn_state_e (3-bit enum) SHALL live in btn_event_pkg; LongTime and GapTime defaults SHALL be added to config_pkg next to ClkFreq and StableTime.
REQ-030 One sub-module, edge_det (registered level, rise/fall outputs), SHALL be used; FSM and counter stay in btn_event_ctrl.
REQ-031 Intended use: db_level_o of debouncer drives db_level_i, sharing clk_i and rst_i.

Verification (ClkFreq=1000, LongTime=5, GapTime=3, so 1 ms = 1 cycle)
REQ-032 Press at cycle 10, release at cycle 12 -> short_o high at cycle 16 only; busy_o low from cycle 16.
REQ-033 Press at cycle 10, hold to cycle 30 -> long_o high at cycle 16 only; IDLE at cycle 31.
REQ-034 Press 10-12, press again 14-15 -> double_o high at cycle 16; no short_o.
REQ-035 Press 10, release at cycle 15 (fall coincides with timeout) -> no long_o; short_o at cycle 19.
REQ-036 Press 10, rst_i pulsed at cycle 12, release 20 -> no pulses; state_o = IDLE from cycle 12.
REQ-037 en_i low with press/release toggling -> all pulses 0; en_i high while level high -> no event until the next rise.
